add_1_bit: RTL and testbench



---
 rtl/add_1_bit_pkg.sv | 11 +
 rtl/full_adder_cell.sv | 13 +
 rtl/add_1_bit.sv | 79 +++++++
 tb/tb_add_1_bit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/add_1_bit_pkg.sv
// rtl/add_1_bit_pkg.sv - shared types and limits for the registered 1-bit adder
package add_1_bit_pkg;

  localparam int ADD_1_BIT_MAX_LATENCY = 4;

  typedef struct packed {
    logic c1;
    logic s;
  } sum_carry_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder leaf
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_1_bit.sv
// rtl/add_1_bit.sv - registered full adder with valid pipeline and bit-serial carry chaining
module add_1_bit
  import add_1_bit_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c0,
  input  logic chain_en,
  input  logic chain_first,
  output logic s,
  output logic c1,
  output logic out_valid
);

  if (LATENCY < 1 || LATENCY > ADD_1_BIT_MAX_LATENCY) begin : g_bad_latency
    $error("add_1_bit: LATENCY must be in 1..%0d", ADD_1_BIT_MAX_LATENCY);
  end

  logic       carry_q;
  logic       cin;
  logic       s_comb;
  logic       c_comb;

  // Only a non-first chained beat consumes the stored carry.
  assign cin = (chain_en && !chain_first) ? carry_q : c0;

  full_adder_cell u_cell (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s_comb),
    .cout (c_comb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (in_valid && chain_en) begin
      carry_q <= c_comb;
    end
  end

  logic       [LATENCY:0] v_chain;
  sum_carry_t [LATENCY:0] d_chain;

  assign v_chain[0] = in_valid;
  assign d_chain[0] = '{c1: c_comb, s: s_comb};

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic       valid_q;
    sum_carry_t data_q;

    // Data only advances with a valid beat so outputs hold the last valid result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= v_chain[i];
        if (v_chain[i]) begin
          data_q <= d_chain[i];
        end
      end
    end

    assign v_chain[i+1] = valid_q;
    assign d_chain[i+1] = data_q;
  end

  assign out_valid = v_chain[LATENCY];
  assign s         = d_chain[LATENCY].s;
  assign c1        = d_chain[LATENCY].c1;

endmodule

// File: tb/tb_add_1_bit.sv
// tb/tb_add_1_bit.sv - directed self-checking bench for add_1_bit (LATENCY 1 and 3)
module tb_add_1_bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c0 = 1'b0;
  logic chain_en = 1'b0;
  logic chain_first = 1'b0;

  logic s1, c11, ov1;
  logic s3, c13, ov3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_1_bit #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c0(c0),
    .chain_en(chain_en), .chain_first(chain_first),
    .s(s1), .c1(c11), .out_valid(ov1)
  );

  add_1_bit #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c0(c0),
    .chain_en(chain_en), .chain_first(chain_first),
    .s(s3), .c1(c13), .out_valid(ov3)
  );

  // Compares {out_valid, c1, s}.
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {ov,c1,s}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic ia, input logic ib, input logic ic,
                      input logic ce, input logic cf);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; c0 = ic; chain_en = ce; chain_first = cf;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] tt_in  [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b100, 3'b110};
  logic [1:0] tt_out [6] = '{2'b00,  2'b01,  2'b10,  2'b11,  2'b01,  2'b10};

  logic [3:0] op_a = 4'b1011;
  logic [3:0] op_b = 4'b0110;
  logic [3:0] exp_s = 4'b0001;

  logic       r_v  [52];
  logic [1:0] r_sc [52];
  logic [1:0] last_sc;

  initial begin
    // Reset state
    #12;
    check("reset_l1", {ov1, c11, s1}, 3'b000);
    check("reset_l3", {ov3, c13, s3}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=3 random stream, chain_en=0
    for (int j = 0; j < 52; j++) begin
      logic iv, ia, ib, ic;
      int sum;
      iv = (j < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      ic = 1'($urandom_range(0, 1));
      sum = int'(ia) + int'(ib) + int'(ic);
      r_v[j]  = iv;
      r_sc[j] = 2'(sum);
      step(iv, ia, ib, ic, 1'b0, 1'b0);
      if (j >= 2) begin
        if (r_v[j-2]) last_sc = r_sc[j-2];
        check($sformatf("stream_%0d", j), {ov3, c13, s3}, {r_v[j-2], last_sc});
      end else begin
        last_sc = 2'b00;
        check($sformatf("stream_%0d", j), {ov3, c13, s3}, 3'b000);
      end
    end

    // Truth table, LATENCY=1
    for (int i = 0; i < 6; i++) begin
      logic [2:0] v;
      v = tt_in[i];
      step(1'b1, v[2], v[1], v[0], 1'b0, 1'b0);
      check($sformatf("tt_%b", v), {ov1, c11, s1}, {1'b1, tt_out[i]});
    end

    // Serial add 1011 + 0110, LSB first
    for (int i = 0; i < 4; i++) begin
      step(1'b1, op_a[i], op_b[i], 1'b0, 1'b1, (i == 0));
      check($sformatf("serial_s%0d", i), {ov1, s1}, {1'b1, exp_s[i]});
    end
    check("serial_cout", {2'b00, c11}, 3'b001);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_l1", {ov1, c11, s1}, 3'b000);
    check("async_rst_l3", {ov3, c13, s3}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("post_rst_chain", {ov1, c11, s1}, 3'b110);

    // Interleave chained / non-chained beats
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("il_first", {ov1, c11, s1}, 3'b110);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("il_plain", {ov1, c11, s1}, 3'b100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("il_chain", {ov1, c11, s1}, 3'b101);

    // Hold behaviour
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_load", {ov1, c11, s1}, 3'b111);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i), 1'(i >> 1), 1'b0, 1'b0, 1'b0);
      check($sformatf("hold_%0d", i), {ov1, c11, s1}, 3'b011);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
